// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state, line-level and parity definitions
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic UART_MARK  = 1'b1;
  localparam logic UART_SPACE = 1'b0;

  // Parity mode encoding, also used by the receiver
  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_t;

  // Data narrower than 8 bits is zero-extended by the caller; the extra
  // zeros do not change the XOR.
  function automatic logic parity_bit(input logic [7:0] data, input parity_mode_t mode);
    logic p;
    p = ^data;
    if (mode == PAR_ODD) begin
      p = ~p;
    end else if (mode == PAR_NONE) begin
      p = UART_SPACE;
    end
    return p;
  endfunction

endpackage

// File: rtl/baud_tick_detect.sv
// rtl/baud_tick_detect.sv - one-Clk tick on each rising edge of the baud level
// Ports:
//   Clk     in  system clock
//   reset   in  synchronous active-high reset
//   baud_in in  toggling baud level, one full period per bit time
//   tick    out high for one Clk when baud_in has just risen
module baud_tick_detect (
  input  logic Clk,
  input  logic reset,
  input  logic baud_in,
  output logic tick
);

  logic baud_q;

  always_ff @(posedge Clk) begin
    if (reset) begin
      baud_q <= 1'b0;
    end else begin
      baud_q <= baud_in;
    end
  end

  assign tick = baud_in & ~baud_q;

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmit serializer paced by the baud generator level
// Ports:
//   Clk      in  system clock
//   reset    in  synchronous active-high reset
//   baud_in  in  toggling baud level, one full period per bit time
//   tx_data  in  character to send (DATA_BITS wide)
//   tx_valid in  tx_data is valid
//   tx_ready out character can be accepted (IDLE only)
//   tx_out   out serial line, idles at mark
//   tx_busy  out acceptance through end of last stop bit
//   tx_done  out one-Clk pulse at end of last stop bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 baud_in,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam parity_mode_t PAR_MODE  = (PARITY_EN != 0) ?
                                       ((PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN) : PAR_NONE;
  localparam logic [3:0]   LAST_DATA = 4'(DATA_BITS);
  localparam logic         LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_t            state, next_state;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_out_d, tx_busy_d, tx_done_d;
  logic                 tick;

  baud_tick_detect u_tick (
    .Clk    (Clk),
    .reset  (reset),
    .baud_in(baud_in),
    .tick   (tick)
  );

  always_ff @(posedge Clk) begin
    if (reset) begin
      state      <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_out     <= UART_MARK;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= next_state;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      tx_out     <= tx_out_d;
      tx_busy    <= tx_busy_d;
      tx_done    <= tx_done_d;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (tx_valid) next_state = SYNC;
      SYNC:    if (tick) next_state = START;
      START:   if (tick) next_state = DATA;
      DATA:    if (tick && bit_cnt_q == LAST_DATA) next_state = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (tick) next_state = STOP;
      STOP:    if (tick && stop_cnt_q == LAST_STOP) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Every line transition is registered, so tx_out moves in the Clk cycle
  // after baud_in rises.
  always_comb begin
    tx_ready   = (state == IDLE);
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    tx_out_d   = tx_out;
    tx_busy_d  = tx_busy;
    tx_done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        tx_out_d = UART_MARK;
        if (tx_valid) begin
          shift_d    = tx_data;
          parity_d   = parity_bit(8'(tx_data), PAR_MODE);
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          tx_busy_d  = 1'b1;
        end
      end
      SYNC: begin
        if (tick) tx_out_d = UART_SPACE;
      end
      START: begin
        if (tick) begin
          tx_out_d  = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = 4'd1;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_DATA) begin
            tx_out_d   = (PARITY_EN != 0) ? parity_q : UART_MARK;
            stop_cnt_d = 1'b0;
          end else begin
            tx_out_d  = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          tx_out_d   = UART_MARK;
          stop_cnt_d = 1'b0;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            tx_busy_d = 1'b0;
            tx_done_d = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: tx_out_d = UART_MARK;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed bench for uart_tx in 8N1, 8E1, 8O1 and 8N2 builds
module tb_uart_tx;

  logic       Clk = 1'b0;
  logic       reset;
  logic       baud_in;
  logic       baud_run;
  logic [7:0] tx_data;
  logic [3:0] tx_valid_v;
  wire  [3:0] ready_w, out_w, busy_w, done_w;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt0 = 0;
  int baud_cnt;

  localparam bit [3:0] PAR_EN_CFG = 4'b0110;
  localparam bit [3:0] ODD_CFG    = 4'b0100;
  int stop_cfg[4] = '{1, 1, 1, 2};

  always #5 Clk = ~Clk;

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_8n1 (
    .Clk(Clk), .reset(reset), .baud_in(baud_in), .tx_data(tx_data), .tx_valid(tx_valid_v[0]),
    .tx_ready(ready_w[0]), .tx_out(out_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_8e1 (
    .Clk(Clk), .reset(reset), .baud_in(baud_in), .tx_data(tx_data), .tx_valid(tx_valid_v[1]),
    .tx_ready(ready_w[1]), .tx_out(out_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_8o1 (
    .Clk(Clk), .reset(reset), .baud_in(baud_in), .tx_data(tx_data), .tx_valid(tx_valid_v[2]),
    .tx_ready(ready_w[2]), .tx_out(out_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_8n2 (
    .Clk(Clk), .reset(reset), .baud_in(baud_in), .tx_data(tx_data), .tx_valid(tx_valid_v[3]),
    .tx_ready(ready_w[3]), .tx_out(out_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

  // Baud generator model: toggles every 4 Clk (bit time 8 Clk), cleared by reset
  initial begin
    baud_in  = 1'b0;
    baud_cnt = 0;
    forever begin
      @(posedge Clk);
      #1;
      if (reset) begin
        baud_in  = 1'b0;
        baud_cnt = 0;
      end else if (baud_run) begin
        baud_cnt++;
        if (baud_cnt == 4) begin
          baud_cnt = 0;
          baud_in  = ~baud_in;
        end
      end
    end
  end

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (done_w[0]) done_cnt0 <= done_cnt0 + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input int idx);
    int n;
    n = 0;
    while (ready_w[idx] !== 1'b1 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check_eq("ready_wait", 32'(n < 100), 32'd1);
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge
  task automatic send(input int idx, input logic [7:0] data, input logic [7:0] later_data);
    wait_ready(idx);
    tx_data = data;
    tx_valid_v[idx] = 1'b1;
    @(negedge Clk);
    tx_valid_v[idx] = 1'b0;
    tx_data = later_data;
    check_eq("accept_busy", 32'(busy_w[idx]), 32'd1);
    check_eq("accept_ready", 32'(ready_w[idx]), 32'd0);
  endtask

  task automatic wait_fall(input int idx, input string tag);
    int w;
    w = 0;
    while (out_w[idx] === 1'b1 && w < 40) begin
      w++;
      @(negedge Clk);
    end
    check_eq($sformatf("%s_sync_wait", tag), 32'(w >= 1 && w <= 8), 32'd1);
  endtask

  // Starts at the negedge after acceptance; samples every Clk of the frame.
  // freeze_bit >= 0 stalls baud_in for 50 Clk inside that bit.
  task automatic check_frame(input int idx, input logic [7:0] data, input string tag,
                             input int freeze_bit, output int fall_cyc);
    logic exp_bits[12];
    int   nb, bad;
    logic mid;
    for (int i = 0; i < 12; i++) exp_bits[i] = 1'b1;
    exp_bits[0] = 1'b0;
    nb = 1;
    for (int i = 0; i < 8; i++) begin
      exp_bits[nb] = data[i];
      nb++;
    end
    if (PAR_EN_CFG[idx]) begin
      exp_bits[nb] = (^data) ^ ODD_CFG[idx];
      nb++;
    end
    nb = nb + stop_cfg[idx];
    bad = 0;
    mid = 1'b0;
    fall_cyc = 0;
    wait_fall(idx, tag);
    if (out_w[idx] !== 1'b0) return;
    fall_cyc = cyc;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 8; j++) begin
        if (out_w[idx] !== exp_bits[b]) bad++;
        if (busy_w[idx] !== 1'b1 || ready_w[idx] !== 1'b0 || done_w[idx] !== 1'b0) bad++;
        if (j == 4) mid = out_w[idx];
        if (b == freeze_bit && j == 2) begin
          baud_run = 1'b0;
          repeat (50) begin
            @(negedge Clk);
            if (out_w[idx] !== exp_bits[b] || busy_w[idx] !== 1'b1) bad++;
          end
          baud_run = 1'b1;
        end
        @(negedge Clk);
      end
      check_eq($sformatf("%s_bit%0d", tag, b), 32'(mid), 32'(exp_bits[b]));
    end
    check_eq($sformatf("%s_bad_samples", tag), 32'(bad), 32'd0);
    check_eq($sformatf("%s_done", tag), 32'(done_w[idx]), 32'd1);
    check_eq($sformatf("%s_busy_end", tag), 32'(busy_w[idx]), 32'd0);
    check_eq($sformatf("%s_ready_end", tag), 32'(ready_w[idx]), 32'd1);
    check_eq($sformatf("%s_line_end", tag), 32'(out_w[idx]), 32'd1);
    @(negedge Clk);
    check_eq($sformatf("%s_done_pulse", tag), 32'(done_w[idx]), 32'd0);
  endtask

  initial begin
    int f1, f2, dc;
    reset      = 1'b1;
    baud_run   = 1'b1;
    tx_data    = 8'h00;
    tx_valid_v = 4'b0000;
    repeat (3) @(negedge Clk);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rst_out%0d", i), 32'(out_w[i]), 32'd1);
      check_eq($sformatf("rst_busy%0d", i), 32'(busy_w[i]), 32'd0);
      check_eq($sformatf("rst_done%0d", i), 32'(done_w[i]), 32'd0);
      check_eq($sformatf("rst_ready%0d", i), 32'(ready_w[i]), 32'd1);
    end
    // reset wins over a simultaneous tx_valid
    tx_valid_v[0] = 1'b1;
    tx_data = 8'hA5;
    @(negedge Clk);
    tx_valid_v[0] = 1'b0;
    check_eq("rst_vs_valid", 32'(busy_w[0]), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge Clk);

    // 8N1 0xA5
    send(0, 8'hA5, 8'hA5);
    check_frame(0, 8'hA5, "n1_a5", -1, f1);
    // 8E1, 8O1, 8N2 with 0xA5 (four ones: even parity 0, odd parity 1)
    send(1, 8'hA5, 8'hA5);
    check_frame(1, 8'hA5, "e1_a5", -1, f1);
    send(2, 8'hA5, 8'hA5);
    check_frame(2, 8'hA5, "o1_a5", -1, f1);
    send(3, 8'hA5, 8'hA5);
    check_frame(3, 8'hA5, "n2_a5", -1, f1);
    send(1, 8'h01, 8'h01);
    check_frame(1, 8'h01, "e1_01", -1, f1);

    // tx_valid held: 0x00 then 0xFF
    wait_ready(0);
    tx_data = 8'h00;
    tx_valid_v[0] = 1'b1;
    @(negedge Clk);
    tx_data = 8'hFF;
    check_eq("b2b_busy", 32'(busy_w[0]), 32'd1);
    check_frame(0, 8'h00, "b2b_00", -1, f1);
    tx_valid_v[0] = 1'b0;
    check_eq("b2b_reaccept", 32'(busy_w[0]), 32'd1);
    check_frame(0, 8'hFF, "b2b_ff", -1, f2);
    check_eq("b2b_gap", 32'((f2 - (f1 + 72)) >= 16), 32'd1);

    // tx_data changes after acceptance
    send(0, 8'h81, 8'h3C);
    check_frame(0, 8'h81, "hold_81", -1, f1);

    // reset during data bit 3
    send(0, 8'hA5, 8'hA5);
    wait_fall(0, "rst_mid");
    repeat (35) @(negedge Clk);
    dc = done_cnt0;
    reset = 1'b1;
    @(negedge Clk);
    reset = 1'b0;
    check_eq("rst_mid_out", 32'(out_w[0]), 32'd1);
    check_eq("rst_mid_ready", 32'(ready_w[0]), 32'd1);
    check_eq("rst_mid_busy", 32'(busy_w[0]), 32'd0);
    repeat (30) @(negedge Clk);
    check_eq("rst_mid_no_done", 32'(done_cnt0 - dc), 32'd0);
    check_eq("rst_mid_idle_line", 32'(out_w[0]), 32'd1);
    send(0, 8'h55, 8'h55);
    check_frame(0, 8'h55, "post_rst_55", -1, f1);

    // baud_in frozen for 50 Clk inside data bit 2
    send(0, 8'hC3, 8'hC3);
    check_frame(0, 8'hC3, "freeze_c3", 3, f1);

    repeat (5) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmit serializer directly downstream of the baud rate generator. It consumes the generator's toggling baud_out level, one full period of which is one bit time, and shifts out a framed character on tx_out. Framing is start bit, DATA_BITS data bits LSB first, optional parity, then 1 or 2 stop bits. Characters arrive from the host side through a valid/ready handshake.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..8
PARITY_EN, 0, 1 inserts a parity bit after the data bits
PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
Clk  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset
baud_in  input  1  toggling baud level from the baud rate generator; one full period is one bit time
tx_data  input  DATA_BITS  character to send
tx_valid  input  1  tx_data is valid
tx_ready  output  1  block can accept a character; high only in IDLE
tx_out  output  1  serial line; idles high (mark)
tx_busy  output  1  high from acceptance until the frame completes
tx_done  output  1  one-Clk pulse when the last stop bit completes

Behaviour:
- Interface: one clock, Clk. reset is synchronous and active-high.
- Reset values: tx_out=1, tx_busy=0, tx_done=0, state=IDLE, baud_q=0, shift register=0, bit counter=0. tx_ready therefore reads 1 in the first cycle after reset.
- Bit tick: tick = baud_in & ~baud_q, where baud_q is baud_in registered. Each baud_in rising edge produces exactly one tick. The generator also resets baud_out to 0, so no spurious tick occurs after reset.
- States: IDLE, SYNC, START, DATA, PARITY, STOP.
- tx_ready = (state==IDLE). A character is accepted when tx_valid & tx_ready.
  - On acceptance, tx_data is latched into the shift register and the parity bit is computed: XOR of the data bits, inverted when PARITY_ODD=1.
  - State goes to SYNC and tx_busy=1.
- IDLE: tx_out=1. tx_valid while not in IDLE is ignored. Later changes to tx_data never affect a latched frame.
- SYNC: wait for a tick. On the tick, tx_out=0 and state goes to START.
- START -> DATA on the next tick. That tick drives tx_out=shift[0], shifts right, and sets the bit counter to 1.
- DATA: each tick drives the next data bit and increments the counter. After DATA_BITS bits, the next tick goes to PARITY (tx_out=parity) when PARITY_EN=1. Otherwise it goes to STOP with tx_out=1.
- PARITY -> STOP on the next tick, driving tx_out=1.
- STOP: stays STOP_BITS bit times. The tick that ends the last stop bit does all of the following:
  - state goes to IDLE;
  - tx_busy goes to 0;
  - tx_done pulses for one cycle.
- Latency:
  - tx_out changes in the Clk cycle after baud_in rises (one register stage).
  - The start bit begins at the first baud_in rising edge after acceptance, which is 1..(bit time) Clk later.
- Each bit on tx_out lasts exactly one baud_in period.
- Back-to-back frames: acceptance happens only in IDLE, and SYNC then waits for the next edge. The minimum mark time between frames is therefore STOP_BITS plus one bit time. Gap-free streaming is out of scope.
- Reset mid-frame: on the next Clk, all registers return to their reset values and tx_out=1. The partial frame is abandoned and tx_done does not pulse.
- reset and tx_valid in the same cycle: reset wins and the character is not accepted.
- If baud_in stops toggling, the FSM holds its state and tx_out holds its value. There is no timeout.
- Width rules:
  - The bit counter is 4 bits wide and covers up to DATA_BITS+1.
  - The stop counter is 1 bit wide.
  - The shift register is DATA_BITS wide. It shifts right and zero-fills from the MSB.

Decomposition:
- Shared package uart_pkg holds:
  - the tx_state_t enum (IDLE, SYNC, START, DATA, PARITY, STOP);
  - the constants UART_MARK=1'b1 and UART_SPACE=1'b0;
  - the parity-mode encoding, shared with the future uart_rx.
- One natural sub-module is baud_tick_detect (Clk, reset, baud_in -> tick). The receiver reuses it.

Test Plan:
1. Run with divisor_in=3 (baud_in toggles every 4 Clk, bit time = 8 Clk), 8N1, send 0xA5.
   -> tx_out is 0, then 1,0,1,0,0,1,0,1, then 1. Each bit lasts 8 Clk, tx_done pulses once, and tx_busy is high for 80 Clk plus the sync wait.
2. Same setup with PARITY_EN=1, PARITY_EN=1 with PARITY_ODD=1, and STOP_BITS=2, sending 0xA5.
   -> Parity bit is 0 for even and 1 for odd. With STOP_BITS=2, the high stop time is 16 Clk before tx_done.
3. Hold tx_valid high with 0x00 and then 0xFF queued.
   -> The second frame is accepted only when tx_ready=1, and its start bit begins at least (STOP_BITS+1)×8 Clk after the previous start of stop. Frame contents are exact.
4. Change tx_data to 0x3C one cycle after 0x81 is accepted.
   -> The transmitted bits are 1,0,0,0,0,0,0,1 (0x81).
5. Assert reset for 1 Clk during data bit 3.
   -> tx_out=1 and tx_ready=1 on the next Clk, with no tx_done. A new 0x55 then transmits correctly.
6. Hold baud_in static mid-frame for 50 Clk.
   -> tx_out and the state are frozen. Once toggling resumes, the frame completes correctly.
